// File: rtl/vram_console.sv
// Text console writer: turns a CPU byte stream into VRAM character writes,
// tracks the cursor, and performs line / full-screen clears one cell per cycle.
module vram_console #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 60,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [12:0] vmem_in_addr,
    output logic [7:0]  vmem_in_data,
    output logic        vmem_we,
    output logic [12:0] cursor_addr
);

    localparam int          TOTAL     = COLS * ROWS;
    localparam logic [12:0] LAST_COL  = 13'(COLS - 1);
    localparam logic [12:0] LAST_ROW  = 13'(ROWS - 1);
    localparam logic [12:0] COLS_W    = 13'(COLS);
    localparam logic [12:0] LAST_ADDR = 13'(TOTAL - 1);

    // The screen must fit the 13-bit VRAM window used by the display side.
    if (TOTAL > 6144) begin : g_size_check
        $error("vram_console: COLS*ROWS exceeds 6144");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_LINE = 2'd1,
        CLR_ALL  = 2'd2
    } state_t;

    state_t      state_q;
    logic [12:0] row_q;
    logic [12:0] col_q;
    logic [12:0] base_q;        // row_q * COLS, kept incrementally
    logic [12:0] clr_addr_q;    // next cell to clear
    logic [12:0] clr_end_q;     // last cell of the current clear
    logic        clr_done_q;    // last cell written, leave on next edge
    logic        we_q;
    logic [12:0] addr_q;
    logic [7:0]  data_q;

    logic        accept;
    logic        is_print;
    logic        advance;
    logic [12:0] cursor;
    logic [12:0] row_inc;
    logic [12:0] base_inc;

    // Byte classification and the row/base values a row advance would produce.
    always_comb begin
        cursor   = base_q + col_q;
        accept   = (state_q == IDLE) && in_valid;
        is_print = (in_data >= 8'h20) && (in_data != 8'h7F);
        advance  = accept && ((is_print && (col_q == LAST_COL)) || (in_data == 8'h0A));
        row_inc  = 13'd0;
        base_inc = 13'd0;
        if (row_q != LAST_ROW) begin
            row_inc  = row_q + 13'd1;
            base_inc = base_q + COLS_W;
        end
    end

    // Control FSM, cursor tracking and registered VRAM write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLR_ALL;       // power-on clear follows reset
            row_q      <= '0;
            col_q      <= '0;
            base_q     <= '0;
            clr_addr_q <= '0;
            clr_end_q  <= LAST_ADDR;
            clr_done_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (is_print) begin
                            we_q   <= 1'b1;
                            addr_q <= cursor;
                            data_q <= in_data;
                            if (col_q == LAST_COL) begin
                                col_q <= '0;
                            end else begin
                                col_q <= col_q + 13'd1;
                            end
                        end else begin
                            case (in_data)
                                8'h0D: col_q <= '0;
                                8'h0A: col_q <= '0;
                                8'h08: begin
                                    if (col_q != 13'd0) begin
                                        col_q  <= col_q - 13'd1;
                                        we_q   <= 1'b1;
                                        addr_q <= cursor - 13'd1;
                                        data_q <= CLEAR_CHAR;
                                    end
                                end
                                8'h0C: begin
                                    row_q      <= '0;
                                    col_q      <= '0;
                                    base_q     <= '0;
                                    state_q    <= CLR_ALL;
                                    clr_addr_q <= '0;
                                    clr_end_q  <= LAST_ADDR;
                                    clr_done_q <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                    // New row: move down (wrapping to the top) and blank it.
                    if (advance) begin
                        row_q      <= row_inc;
                        base_q     <= base_inc;
                        state_q    <= CLR_LINE;
                        clr_addr_q <= base_inc;
                        clr_end_q  <= base_inc + LAST_COL;
                        clr_done_q <= 1'b0;
                    end
                end
                CLR_LINE, CLR_ALL: begin
                    // The first clear write lands one cycle after the accepting
                    // edge, so any character write from that byte goes first.
                    if (!clr_done_q) begin
                        we_q   <= 1'b1;
                        addr_q <= clr_addr_q;
                        data_q <= CLEAR_CHAR;
                        if (clr_addr_q == clr_end_q) begin
                            clr_done_q <= 1'b1;
                        end else begin
                            clr_addr_q <= clr_addr_q + 13'd1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign vmem_we      = we_q;
    assign vmem_in_addr = addr_q;
    assign vmem_in_data = data_q;
    assign cursor_addr  = cursor;

endmodule

// File: tb/tb_vram_console.sv
// Directed bench for vram_console: a model pushes every expected VRAM write
// into a scoreboard queue; a monitor pops and compares as writes appear.
module tb_vram_console;

    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] vmem_in_addr;
    logic [7:0]  vmem_in_data;
    logic        vmem_we;
    logic [12:0] cursor_addr;

    vram_console #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .CLEAR_CHAR (8'h20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .vmem_in_addr (vmem_in_addr),
        .vmem_in_data (vmem_in_data),
        .vmem_we      (vmem_we),
        .cursor_addr  (cursor_addr)
    );

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        bit          clr;      // part of a clear burst: in_ready must be low
        bit          follow;   // must come on the cycle right after the previous write
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  last_wr  = -10;
    int  wr_count = 0;
    int  mrow     = 0;
    int  mcol     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cur();
        return mrow * COLS + mcol;
    endfunction

    task automatic push(input int a, input logic [7:0] d, input bit c, input bit f);
        wr_t e;
        e.addr   = 13'(a);
        e.data   = d;
        e.clr    = c;
        e.follow = f;
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input int base, input int n, input bit follow_first);
        for (int i = 0; i < n; i++) push(base + i, 8'h20, 1'b1, (i == 0) ? follow_first : 1'b1);
    endtask

    task automatic adv_row(input bit follow);
        mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
        push_clear(mrow * COLS, COLS, follow);
    endtask

    // Reference behaviour of one accepted byte; busy=1 when a clear follows.
    task automatic model_byte(input logic [7:0] b, output bit busy);
        busy = 1'b0;
        if (b >= 8'h20 && b != 8'h7F) begin
            push(cur(), b, 1'b0, 1'b0);
            if (mcol == COLS - 1) begin
                mcol = 0;
                adv_row(1'b1);
                busy = 1'b1;
            end else begin
                mcol++;
            end
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            mcol = 0;
            adv_row(1'b0);
            busy = 1'b1;
        end else if (b == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                push(cur(), 8'h20, 1'b0, 1'b0);
            end
        end else if (b == 8'h0C) begin
            mrow = 0;
            mcol = 0;
            push_clear(0, COLS * ROWS, 1'b0);
            busy = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bit busy;
        while (in_ready !== 1'b1 && n < 10000) begin
            tick();
            n++;
        end
        if (n >= 10000) check("send_wait_ready", in_ready, 1);
        model_byte(b, busy);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        check("cursor_after_accept", cursor_addr, cur());
        check("ready_after_accept", in_ready, busy ? 1'b0 : 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        tick();
        while (in_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every VRAM write must match the next expected entry.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (vmem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", vmem_we, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", vmem_in_addr, e.addr);
                check("wr_data", vmem_in_data, e.data);
                if (e.clr) check("ready_low_in_clear", in_ready, 0);
                if (e.follow) check("wr_consecutive", cyc - last_wr, 1);
            end
            last_wr = cyc;
            wr_count++;
        end else if (vmem_we !== 1'b0) begin
            check("we_known", vmem_we, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset state.
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #3;
        check("rst_we", vmem_we, 0);
        check("rst_addr", vmem_in_addr, 0);
        check("rst_data", vmem_in_data, 0);
        check("rst_ready", in_ready, 0);
        check("rst_cursor", cursor_addr, 0);

        // Power-on clear.
        push_clear(0, COLS * ROWS, 1'b0);
        base = wr_count;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_done("poweron", 6000);
        check("poweron_count", wr_count - base, COLS * ROWS);
        check("poweron_cursor", cursor_addr, 0);

        // Single character from idle.
        send(8'h41);
        wait_done("char_A", 10);

        // Full row of characters wraps and blanks the next row.
        send(8'h0D);
        for (int i = 0; i < COLS; i++) send(8'h78);
        wait_done("row_fill", 200);
        check("row_fill_cursor", cursor_addr, 80);

        // Backspace at column 0, then after three characters.
        send(8'h0A);
        wait_done("lf_row2", 200);
        check("lf_row2_cursor", cursor_addr, 160);
        send(8'h08);
        wait_done("bs_col0", 10);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(8'h08);
        wait_done("bs_col3", 10);
        check("bs_col3_cursor", cursor_addr, 162);

        // Ignored controls and a high printable byte.
        send(8'h07);
        send(8'h7F);
        send(8'h80);
        wait_done("misc", 10);

        // Walk to row 59, col 5, then LF wraps to the top row.
        send(8'h0D);
        for (int i = 0; i < 57; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h2E);
        wait_done("to_row59", 200);
        check("row59_cursor", cursor_addr, 59 * COLS + 5);
        send(8'h0A);
        wait_done("lf_wrap", 200);
        check("lf_wrap_cursor", cursor_addr, 0);

        // Form feed; bytes offered while busy are ignored; reset mid-clear.
        base = wr_count;
        send(8'h0C);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        repeat (20) tick();
        in_valid = 1'b0;
        n = 0;
        while ((wr_count - base) < 1000 && n < 2000) begin
            tick();
            n++;
        end
        check("abort_point", wr_count - base, 1000);
        rst = 1'b1;
        #1;
        check("abort_we", vmem_we, 0);
        check("abort_ready", in_ready, 0);
        check("abort_cursor", cursor_addr, 0);
        exp_q.delete();
        mrow = 0;
        mcol = 0;
        push_clear(0, COLS * ROWS, 1'b0);
        base = wr_count;
        repeat (3) tick();
        rst = 1'b0;
        wait_done("restart", 6000);
        check("restart_count", wr_count - base, COLS * ROWS);
        check("restart_cursor", cursor_addr, 0);

        // Normal operation after the restarted clear.
        send(8'h51);
        wait_done("post_reset_char", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_console.md
VRAM_CONSOLE -- requirements
Module: vram_console

Interface
REQ-001 Parameter COLS, default 80: characters per text row.
REQ-002 Parameter ROWS, default 60: text rows on screen.
REQ-003 Parameter CLEAR_CHAR, default 8'h20: byte written when clearing a cell.
REQ-004 clk  input  1  system clock (100MHz); all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  8  character or control byte from the CPU.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block can accept a byte; a byte transfers on a rising edge with in_valid=1 and in_ready=1.
REQ-009 vmem_in_addr  output  13  VRAM write address, row*COLS+col.
REQ-010 vmem_in_data  output  8  VRAM write data.
REQ-011 vmem_we  output  1  VRAM write strobe, one write per cycle it is high.
REQ-012 cursor_addr  output  13  current cursor cell address, row*COLS+col.

Function
REQ-013 COLS*ROWS SHALL be at most 6144; simulation SHALL stop with an error otherwise.
REQ-014 vmem_in_addr, vmem_in_data and vmem_we SHALL be registered outputs; in_ready SHALL be high exactly when the FSM is in IDLE.
REQ-015 FSM states SHALL be IDLE, CLR_LINE (clears one row) and CLR_ALL (clears the whole screen); vmem_we SHALL be 0 in IDLE unless a byte was accepted on that edge.
REQ-016 Printable byte (0x20-0x7E, 0x80-0xFF) accepted: next cycle vmem_we=1, addr=old cursor, data=byte; col increments.
REQ-017 Printable byte at col=COLS-1: col<=0, row advances per REQ-020.
REQ-018 0x0D (CR): col<=0; no write.
REQ-019 0x0A (LF): col<=0, row advances per REQ-020; no character write.
REQ-020 Row advance: row<=row+1, or 0 when row=ROWS-1; FSM SHALL enter CLR_LINE for the new row.
REQ-021 0x08 (BS): if col>0 then col<=col-1 and write CLEAR_CHAR at the new cursor next cycle; if col=0 then no write and no cursor change.
REQ-022 0x0C (FF): cursor<=0; FSM SHALL enter CLR_ALL.
REQ-023 Any other byte in 0x00-0x1F or 0x7F SHALL be consumed with no write and no cursor change.
REQ-024 CLR_LINE SHALL write CLEAR_CHAR to row_base..row_base+COLS-1, ascending, one per cycle, on COLS consecutive cycles after the accepting edge, then return to IDLE.
REQ-025 CLR_ALL SHALL write CLEAR_CHAR to 0..COLS*ROWS-1, ascending, one per cycle, then return to IDLE.
REQ-026 Any character or BS write caused by the accepting byte SHALL occur in the cycle before the first clear write; in_ready SHALL stay low during every clear cycle.
REQ-027 cursor_addr SHALL reflect the updated cursor from the edge that accepts the byte.
REQ-028 Bytes presented while in_ready=0 SHALL be ignored; in_data SHALL be sampled only at an accepting edge.
REQ-029 Address arithmetic SHALL be 13-bit, and addresses SHALL never reach COLS*ROWS.

Reset
REQ-030 While rst=1, outputs SHALL be immediately vmem_we=0, vmem_in_addr=0, vmem_in_data=0, in_ready=0 and cursor_addr=0, and row=col=0.
REQ-031 After rst deasserts, the FSM SHALL enter CLR_ALL (power-on clear) before first reaching IDLE.
REQ-032 rst asserted mid-clear or mid-write SHALL abort the operation without completing it, and the power-on clear SHALL restart from address 0.

Verification
REQ-033 Reset release -> 4800 writes of 0x20 at addresses 0..4799 on consecutive cycles, in_ready=0 throughout; then in_ready=1 and cursor_addr=0.
REQ-034 Send 0x41 from idle at cursor 0 -> next cycle vmem_we=1, addr=0, data=0x41; cursor_addr=1; in_ready stays 1.
REQ-035 Send 80 bytes of 0x78 -> writes at 0..79, then 80 writes of 0x20 at 80..159 with in_ready=0; cursor_addr=80.
REQ-036 Cursor at row 59, col 5, send 0x0A -> no character write; clear of addresses 0..79; cursor_addr=0.
REQ-037 BS at cursor 160 -> no write and cursor_addr stays 160; send 'a','b','c' then BS -> write 0x20 at 162, cursor_addr=162.
REQ-038 Send 0x0C, assert rst at clear write 1000 -> vmem_we drops immediately; after release, clear restarts at address 0 and performs 4800 writes.
